// File: rtl/operand_b_stage.sv
// operand_b_stage
//   ALU operand-B stage between register read and the ALU. Resolves rs2
//   against the in-flight writers (lowest index wins). Raises a load-use stall
//   when the winning writer has no data yet. Selects operand B and registers
//   it, together with the forwarded store data, in a one-entry valid/ready
//   slot that supports flush. Also keeps a saturating count of stall cycles.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   upstream handshake; in_ready ignores stall
//   rs2_addr, rs2_data    source register index and regfile read value
//   imm                   decoded immediate
//   select                00 RS2, 01 IMM, 10 ZERO, 11 FOUR
//   needs_rs2             instruction consumes rs2 (gates the hazard)
//   fwd_valid/busy/addr/data  forwarding entries, index 0 youngest
//   flush                 kills the held and the incoming instruction
//   out_valid / out_ready downstream handshake
//   alu_src_b, store_data registered operand B and forwarded rs2 value
//   stall                 combinational load-use hazard
//   stall_cnt             saturating count of hazard cycles
module operand_b_stage #(
    parameter int XLEN        = 32,
    parameter int NUM_FWD     = 2,
    parameter int REG_AW      = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_AW-1:0]         rs2_addr,
    input  logic [XLEN-1:0]           rs2_data,
    input  logic [XLEN-1:0]           imm,
    input  logic [1:0]                select,
    input  logic                      needs_rs2,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_busy,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           alu_src_b,
    output logic [XLEN-1:0]           store_data,
    output logic                      stall,
    output logic [STALL_CNT_W-1:0]    stall_cnt
);

    localparam logic [1:0] SEL_RS2  = 2'b00;
    localparam logic [1:0] SEL_IMM  = 2'b01;
    localparam logic [1:0] SEL_ZERO = 2'b10;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        if (&v) return v;
        return v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [XLEN-1:0]        rs2_fwd;
    logic                   hit_busy;
    logic [XLEN-1:0]        operand;
    logic                   accept;
    logic                   vld_p1;
    logic [XLEN-1:0]        alu_src_b_p1;
    logic [XLEN-1:0]        store_data_p1;
    logic [STALL_CNT_W-1:0] stall_cnt_p1;

    // ---- stage 0: bypass resolution, hazard detect, operand select ----
    // Walk from oldest to youngest so the lowest matching index is the last
    // assignment and therefore wins; its busy bit is the only one that counts.
    always_comb begin
        rs2_fwd  = rs2_data;
        hit_busy = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_addr[i*REG_AW +: REG_AW] == rs2_addr)) begin
                rs2_fwd  = fwd_data[i*XLEN +: XLEN];
                hit_busy = fwd_busy[i];
            end
        end
        if (rs2_addr == '0) begin
            rs2_fwd  = '0;
            hit_busy = 1'b0;
        end
    end

    always_comb begin
        case (select)
            SEL_RS2:  operand = rs2_fwd;
            SEL_IMM:  operand = imm;
            SEL_ZERO: operand = '0;
            default:  operand = {{(XLEN-3){1'b0}}, 3'b100};
        endcase
    end

    assign stall    = in_valid && needs_rs2 && hit_busy;
    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready && !stall && !flush;

    // ---- stage 1: output register slot ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_src_b_p1  <= '0;
            store_data_p1 <= '0;
        end else if (accept) begin
            alu_src_b_p1  <= operand;
            store_data_p1 <= rs2_fwd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_p1 <= '0;
        end else if (stall && !flush) begin
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        end
    end

    assign out_valid  = vld_p1;
    assign alu_src_b  = alu_src_b_p1;
    assign store_data = store_data_p1;
    assign stall_cnt  = stall_cnt_p1;

endmodule

// File: tb/tb_operand_b_stage.sv
module tb_operand_b_stage;

    localparam int XLEN    = 32;
    localparam int NUM_FWD = 2;
    localparam int REG_AW  = 5;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      in_valid;
    logic [REG_AW-1:0]         rs2_addr;
    logic [XLEN-1:0]           rs2_data;
    logic [XLEN-1:0]           imm;
    logic [1:0]                select;
    logic                      needs_rs2;
    logic [NUM_FWD-1:0]        fwd_valid;
    logic [NUM_FWD-1:0]        fwd_busy;
    logic [NUM_FWD*REG_AW-1:0] fwd_addr;
    logic [NUM_FWD*XLEN-1:0]   fwd_data;
    logic                      flush;
    logic                      out_ready;

    wire                       in_ready, out_valid, stall;
    wire [XLEN-1:0]            alu_src_b, store_data;
    wire [15:0]                stall_cnt;
    wire                       sat_in_ready, sat_out_valid, sat_stall;
    wire [XLEN-1:0]            sat_alu_src_b, sat_store_data;
    wire [3:0]                 sat_stall_cnt;

    operand_b_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data), .imm(imm), .select(select),
        .needs_rs2(needs_rs2), .fwd_valid(fwd_valid), .fwd_busy(fwd_busy),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_src_b(alu_src_b),
        .store_data(store_data), .stall(stall), .stall_cnt(stall_cnt)
    );

    operand_b_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW), .STALL_CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data), .imm(imm), .select(select),
        .needs_rs2(needs_rs2), .fwd_valid(fwd_valid), .fwd_busy(fwd_busy),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data), .flush(flush),
        .out_valid(sat_out_valid), .out_ready(out_ready), .alu_src_b(sat_alu_src_b),
        .store_data(sat_store_data), .stall(sat_stall), .stall_cnt(sat_stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [XLEN-1:0] ref_rs2();
        if (rs2_addr == 0) return '0;
        for (int i = 0; i < NUM_FWD; i++)
            if (fwd_valid[i] && fwd_addr[i*REG_AW +: REG_AW] == rs2_addr)
                return fwd_data[i*XLEN +: XLEN];
        return rs2_data;
    endfunction

    function automatic logic ref_stall();
        if (!in_valid || !needs_rs2 || rs2_addr == 0) return 1'b0;
        for (int i = 0; i < NUM_FWD; i++)
            if (fwd_valid[i] && fwd_addr[i*REG_AW +: REG_AW] == rs2_addr)
                return fwd_busy[i];
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] ref_op();
        case (select)
            2'd0:    return ref_rs2();
            2'd1:    return imm;
            2'd2:    return 32'd0;
            default: return 32'd4;
        endcase
    endfunction

    logic            m_valid = 1'b0;
    logic [XLEN-1:0] m_alu = '0, m_store = '0;
    int              m_cnt = 0, m_cnt4 = 0;
    logic            m_st, m_acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_alu = '0; m_store = '0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            m_st  = ref_stall();
            m_acc = in_valid && (!m_valid || out_ready) && !m_st && !flush;
            if (m_st && !flush) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (flush) m_valid = 1'b0;
            else if (m_acc) begin
                m_valid = 1'b1; m_alu = ref_op(); m_store = ref_rs2();
            end else if (out_ready) m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", out_valid, m_valid);
            chk("in_ready", in_ready, !m_valid || out_ready);
            chk("stall", stall, ref_stall());
            chk("stall_cnt", stall_cnt, m_cnt);
            chk("sat_stall_cnt", sat_stall_cnt, m_cnt4);
            chk("sat_out_valid", sat_out_valid, m_valid);
            chk("sat_in_ready", sat_in_ready, !m_valid || out_ready);
            chk("sat_stall", sat_stall, ref_stall());
            if (m_valid) begin
                chk("alu_src_b", alu_src_b, m_alu);
                chk("store_data", store_data, m_store);
                chk("sat_alu_src_b", sat_alu_src_b, m_alu);
                chk("sat_store_data", sat_store_data, m_store);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        in_valid = 0; rs2_addr = 0; rs2_data = 0; imm = 0; select = 0; needs_rs2 = 0;
        fwd_valid = 0; fwd_busy = 0; fwd_addr = 0; fwd_data = 0; flush = 0; out_ready = 1;

        #12;
        chk("reset out_valid", out_valid, 0);
        chk("reset alu_src_b", alu_src_b, 0);
        chk("reset store_data", store_data, 0);
        chk("reset stall_cnt", stall_cnt, 0);
        step();
        rst_n = 1;
        step();

        // select sweep
        in_valid = 1; needs_rs2 = 1; rs2_addr = 3; rs2_data = 32'h11; imm = 32'h22;
        select = 2'd0; step();
        chk("sel rs2", alu_src_b, 32'h11); chk("sel rs2 vld", out_valid, 1);
        chk("sel rs2 store", store_data, 32'h11);
        select = 2'd1; step();
        chk("sel imm", alu_src_b, 32'h22); chk("sel imm store", store_data, 32'h11);
        select = 2'd2; step();
        chk("sel zero", alu_src_b, 32'h0);
        select = 2'd3; step();
        chk("sel four", alu_src_b, 32'h4); chk("sel four store", store_data, 32'h11);

        // forward priority
        select = 2'd0; rs2_addr = 5; fwd_valid = 2'b11; fwd_addr = {5'd5, 5'd5};
        fwd_data = {32'hB, 32'hA}; step();
        chk("fwd youngest", alu_src_b, 32'hA);
        fwd_valid = 2'b10; step();
        chk("fwd older", alu_src_b, 32'hB);
        rs2_addr = 0; step();
        chk("fwd x0", alu_src_b, 32'h0); chk("fwd x0 store", store_data, 32'h0);

        // load-use
        rs2_addr = 7; fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd7}; fwd_busy = 2'b01;
        fwd_data = {32'h0, 32'h77};
        for (int k = 0; k < 3; k++) begin
            #1; chk("lu stall", stall, 1);
            step();
        end
        chk("lu no capture", out_valid, 0);
        chk("lu count", stall_cnt, 3);
        fwd_busy = 2'b00;
        #1; chk("lu clear", stall, 0);
        step();
        chk("lu accept", alu_src_b, 32'h77); chk("lu accept vld", out_valid, 1);
        select = 2'd1; needs_rs2 = 0; fwd_busy = 2'b01;
        #1; chk("imm no stall", stall, 0);
        step();
        chk("imm no stall data", alu_src_b, 32'h22); chk("imm no stall store", store_data, 32'h77);
        chk("imm no stall cnt", stall_cnt, 3);

        // backpressure
        fwd_busy = 0; fwd_valid = 0; in_valid = 0; step();
        out_ready = 0; in_valid = 1; imm = 32'h100; step();
        chk("bp fill", alu_src_b, 32'h100);
        imm = 32'h200;
        for (int k = 0; k < 4; k++) begin
            #1; chk("bp in_ready", in_ready, 0);
            step();
            chk("bp hold", alu_src_b, 32'h100);
        end
        out_ready = 1; imm = 32'h300;
        #1; chk("bp release rdy", in_ready, 1);
        step();
        chk("bp b2b 1", alu_src_b, 32'h300);
        imm = 32'h400; step();
        chk("bp b2b 2", alu_src_b, 32'h400); chk("bp b2b vld", out_valid, 1);

        // flush
        out_ready = 0; imm = 32'h500; flush = 1; step();
        chk("flush kill", out_valid, 0);
        flush = 0; in_valid = 0; step();
        chk("flush dropped", out_valid, 0);

        // flush during stall does not count
        out_ready = 1; in_valid = 1; needs_rs2 = 1; select = 2'd0; rs2_addr = 7;
        fwd_valid = 2'b01; fwd_busy = 2'b01; flush = 1; step();
        chk("flush stall cnt", stall_cnt, 3);
        flush = 0;

        // saturation
        for (int k = 0; k < 20; k++) step();
        chk("sat main cnt", stall_cnt, 23);
        chk("sat cnt4", sat_stall_cnt, 4'hF);

        // reset mid-stall with an entry held
        fwd_busy = 0; out_ready = 0; step();
        chk("pre-reset vld", out_valid, 1);
        fwd_busy = 2'b01; step();
        rst_n = 0;
        #1;
        chk("arst out_valid", out_valid, 0);
        chk("arst alu_src_b", alu_src_b, 0);
        chk("arst store_data", store_data, 0);
        chk("arst stall_cnt", stall_cnt, 0);
        chk("arst sat cnt", sat_stall_cnt, 0);
        step();
        in_valid = 0; out_ready = 1; rst_n = 1;
        step(); step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
